// File: rtl/display_scan_7seg_pkg.sv
// Glyph and digit-enable constants shared by the scan driver
// and any static seven-segment display.
package display_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/display_scan_7seg_if.sv
// Digit source / display bus between the counter chain and the
// scan driver.
interface display_scan_7seg_if;

    logic [15:0] bcd_in;
    logic        enable;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    modport master (
        output bcd_in, enable, blank_lz, blink_mask,
        input  seg, an, frame_start
    );

    modport slave (
        input  bcd_in, enable, blank_lz, blink_mask,
        output seg, an, frame_start
    );

endinterface

// File: rtl/display_scan_7seg_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder;
// non-BCD codes render as a dash.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        unique case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_7seg.sv
// Four-digit multiplexed seven-segment driver with frame latch,
// leading-zero blanking and per-digit blinking.
module display_scan_7seg
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125
) (
    input logic           clock,
    input logic           reset,
    display_scan_7seg_if.slave bus
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

    logic [TW-1:0] tick;
    logic [1:0]    idx;
    logic          primed;
    logic [15:0]   frame;
    logic [FW-1:0] fcnt;
    logic          phase;

    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          fs_q;

    logic          term;
    logic          load;
    logic          wrap;
    logic [3:0]    digit;
    logic          dark;
    logic [6:0]    glyph;
    logic [3:0]    an_next;

    bcd_to_7seg u_dec (
        .digit (digit),
        .seg   (glyph)
    );

    always_comb begin
        term  = (tick == TICK_MAX);
        load  = !primed || (idx == 2'd3 && term);
        wrap  = (fcnt == FCNT_MAX);
        digit = frame[3:0];
        unique case (idx)
            2'd0: digit = frame[3:0];
            2'd1: digit = frame[7:4];
            2'd2: digit = frame[11:8];
            2'd3: digit = frame[15:12];
        endcase
        // Zero-blanking cascades: digit 2 only blanks behind a blank digit 3
        dark = !bus.enable
            || (bus.blink_mask[idx] && phase)
            || (bus.blank_lz && idx == 2'd3 && digit == 4'd0)
            || (bus.blank_lz && idx == 2'd2
                && frame[15:12] == 4'd0 && digit == 4'd0);
        an_next = dark ? AN_OFF : ~(4'b0001 << idx);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick   <= '0;
            idx    <= 2'd0;
            primed <= 1'b0;
            frame  <= 16'h0000;
            fcnt   <= '0;
            phase  <= 1'b0;
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
            fs_q   <= 1'b0;
        end else begin
            tick   <= term ? '0 : tick + 1'b1;
            idx    <= term ? idx + 2'd1 : idx;
            primed <= 1'b1;
            fs_q   <= load;
            if (load) frame <= bus.bcd_in;
            // The priming load does not count toward the blink period
            if (load && primed) begin
                if (wrap) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
            seg_q <= dark ? SEG_OFF : glyph;
            an_q  <= an_next;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_7seg.sv
// Directed bench for the multiplexed seven-segment driver
// with SCAN_DIV=4 and BLINK_FRAMES=2.
module tb_display_scan_7seg;

    typedef struct {
        string       name;
        logic [15:0] bcd;
        logic        en;
        logic        lz;
        logic [3:0]  mask;
        logic [15:0] an_all;
        logic [27:0] seg_all;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   edge_n;

    display_scan_7seg_if dut_if ();

    display_scan_7seg #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic [15:0] b, logic e,
                                logic lz, logic [3:0] m,
                                logic [15:0] a, logic [27:0] s);
        vec_t v;
        v.name = n;
        v.bcd = b;
        v.en = e;
        v.lz = lz;
        v.mask = m;
        v.an_all = a;
        v.seg_all = s;
        return v;
    endfunction

    task automatic chk(string nm, logic [3:0] ea, logic [6:0] es,
                       logic efs);
        n_checks++;
        if (dut_if.an !== ea || dut_if.seg !== es
            || dut_if.frame_start !== efs) begin
            n_fail++;
            $display("FAIL %s edge %0d: an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
                     nm, edge_n, dut_if.an, dut_if.seg,
                     dut_if.frame_start, ea, es, efs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        chk("reset", 4'b1111, 7'b1111111, 1'b0);
        rst = 1'b0;
        edge_n = 0;
    endtask

    vec_t vecs [8];

    initial begin
        n_checks = 0;
        n_fail = 0;
        edge_n = 0;
        rst = 1'b1;
        dut_if.bcd_in = 16'h0000;
        dut_if.enable = 1'b1;
        dut_if.blank_lz = 1'b0;
        dut_if.blink_mask = 4'b0000;

        // an_all / seg_all are {digit3, digit2, digit1, digit0}
        vecs[0] = mk("plain_5930", 16'h5930, 1, 0, 4'b0000, 16'h7BDE,
                     {7'h12, 7'h10, 7'h30, 7'h40});
        vecs[1] = mk("lz_0007", 16'h0007, 1, 1, 4'b0000, 16'hFFDE,
                     {7'h7F, 7'h7F, 7'h40, 7'h78});
        vecs[2] = mk("dash_AB0F", 16'hAB0F, 1, 0, 4'b0000, 16'h7BDE,
                     {7'h3F, 7'h3F, 7'h40, 7'h3F});
        vecs[3] = mk("lz_0305", 16'h0305, 1, 1, 4'b0000, 16'hFBDE,
                     {7'h7F, 7'h30, 7'h40, 7'h12});
        vecs[4] = mk("disabled", 16'h1234, 0, 0, 4'b0000, 16'hFFFF,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        vecs[5] = mk("lz_0000", 16'h0000, 1, 1, 4'b0000, 16'hFFDE,
                     {7'h7F, 7'h7F, 7'h40, 7'h40});
        vecs[6] = mk("lz_1000_mask", 16'h1000, 1, 1, 4'b0101, 16'h7BDE,
                     {7'h79, 7'h40, 7'h40, 7'h40});
        vecs[7] = mk("lz_8601", 16'h8601, 1, 1, 4'b0000, 16'h7BDE,
                     {7'h00, 7'h02, 7'h40, 7'h79});

        foreach (vecs[v]) begin
            dut_if.bcd_in = vecs[v].bcd;
            dut_if.enable = vecs[v].en;
            dut_if.blank_lz = vecs[v].lz;
            dut_if.blink_mask = vecs[v].mask;
            do_reset();
            for (int e = 1; e <= 32; e++) begin
                int i;
                logic [3:0] ea;
                logic [6:0] es;
                step();
                i = ((e - 1) / 4) % 4;
                ea = vecs[v].an_all[i*4 +: 4];
                es = vecs[v].seg_all[i*7 +: 7];
                // Edge 1 still shows digit 0 of the cleared latch
                if (e == 1) es = (ea == 4'b1111) ? 7'h7F : 7'h40;
                chk(vecs[v].name, ea, es, (e == 1) || (e % 16 == 0));
            end
        end

        // bcd_in change mid-frame stays hidden until the next load
        dut_if.bcd_in = 16'h5930;
        dut_if.enable = 1'b1;
        dut_if.blank_lz = 1'b0;
        dut_if.blink_mask = 4'b0000;
        do_reset();
        repeat (8) step();
        chk("midframe_e8", 4'b1101, 7'h30, 1'b0);
        dut_if.bcd_in = 16'h1234;
        repeat (2) step();
        chk("midframe_e10", 4'b1011, 7'h10, 1'b0);
        repeat (4) step();
        chk("midframe_e14", 4'b0111, 7'h12, 1'b0);
        repeat (2) step();
        chk("midframe_e16", 4'b0111, 7'h12, 1'b1);
        step();
        chk("midframe_e17", 4'b1110, 7'h19, 1'b0);
        repeat (4) step();
        chk("midframe_e21", 4'b1101, 7'h30, 1'b0);

        // Blink: frames 0-1 on, 2-3 off, 4-5 on for digits 3/2
        dut_if.bcd_in = 16'h1234;
        dut_if.blink_mask = 4'b1100;
        do_reset();
        for (int e = 1; e <= 96; e++) begin
            int i;
            int k;
            logic [3:0] ea;
            logic [6:0] es;
            logic [27:0] glyphs;
            glyphs = {7'h79, 7'h24, 7'h30, 7'h19};
            step();
            i = ((e - 1) / 4) % 4;
            k = (e - 1) / 16;
            ea = ~(4'b0001 << i);
            es = glyphs[i*7 +: 7];
            if (e == 1) es = 7'h40;
            if (i >= 2 && ((k / 2) % 2) == 1) begin
                ea = 4'b1111;
                es = 7'h7F;
            end
            chk("blink", ea, es, (e == 1) || (e % 16 == 0));
        end

        // enable drop mid-slot, then restore without disturbing scan
        dut_if.blink_mask = 4'b0000;
        do_reset();
        repeat (6) step();
        chk("en_e6", 4'b1101, 7'h30, 1'b0);
        dut_if.enable = 1'b0;
        step();
        chk("en_off_e7", 4'b1111, 7'h7F, 1'b0);
        step();
        chk("en_off_e8", 4'b1111, 7'h7F, 1'b0);
        dut_if.enable = 1'b1;
        step();
        chk("en_on_e9", 4'b1011, 7'h24, 1'b0);
        repeat (3) step();
        chk("en_on_e12", 4'b1011, 7'h24, 1'b0);
        step();
        chk("en_on_e13", 4'b0111, 7'h79, 1'b0);

        // Asynchronous reset between edges, then re-prime
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 4'b1111, 7'h7F, 1'b0);
        #1;
        rst = 1'b0;
        edge_n = 0;
        step();
        chk("reprime_e1", 4'b1110, 7'h40, 1'b1);
        step();
        chk("reprime_e2", 4'b1110, 7'h19, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
